dffnr_pipe: RTL and testbench
=============================

Name: dffnr_pipe

Overview:
- Parametrised successor to the single-bit falling-edge, reset-clearable flop.
- A WIDTH-bit, DEPTH-stage pipeline, clocked on the falling edge, with per-stage valid tracking, a stall enable, synchronous clear and an occupancy count.
- Used as a retiming/delay line in negative-edge clock domains of the digital core; replaces chains of discrete dffnrnq cells.

Parameters:
- WIDTH, 8: data bits per stage; legal range 1..64.
- DEPTH, 4: pipeline stages, equal to latency in enabled falling edges; legal range 1..32.
- RESET_VAL, 0: WIDTH-bit value loaded into every data stage on reset or clear.
- GATE_INVALID, 0: 1 = data captured with DV=0 is replaced by RESET_VAL; 0 = data is captured unconditionally.

Ports:
- CLKN  input  1  clock; all state updates on the falling edge.
- R  input  1  asynchronous reset, active-high.
- EN  input  1  advance enable; 0 freezes all state.
- SCLR  input  1  synchronous clear, sampled on the falling edge of CLKN.
- D  input  WIDTH  data into stage 0.
- DV  input  1  valid qualifier for D.
- Q  output  WIDTH  data of stage DEPTH-1, registered.
- QV  output  1  valid of stage DEPTH-1.
- CNT  output  $clog2(DEPTH+1)  number of valid stages, range 0..DEPTH.

Behaviour:
- Reset: while R=1, regardless of CLKN:
  - all data stages = RESET_VAL, so Q=RESET_VAL;
  - all valids = 0, so QV=0;
  - CNT=0.
  - This takes effect immediately on R rising, not at the next edge.
- Reset release: R falling has no effect until the next falling edge of CLKN. The first falling edge with R=0 is a normal edge.
- Priority at each falling edge of CLKN, with R=0: SCLR > EN.
  - SCLR=1: same end state as reset (data=RESET_VAL, valids=0, CNT=0). EN is ignored.
  - SCLR=0, EN=1 (advance):
    - stage0.data <= (GATE_INVALID && !DV) ? RESET_VAL : D;
    - stage0.v <= DV;
    - stage i <= stage i-1 for i=1..DEPTH-1.
  - SCLR=0, EN=0: all stages and CNT hold.
- Latency: a word presented with EN=1 at edge k appears on Q/QV right after edge k+DEPTH-1. With DEPTH=1, it appears directly after edge k.
- CNT is registered and tracks occupancy:
  - on an advance, CNT <= CNT + DV - QV_old, where QV_old is the valid of the last stage before the edge;
  - simultaneous entry and exit leaves CNT unchanged;
  - CNT never exceeds DEPTH and never underflows. Both are guaranteed by construction and must hold as an assertion.
- No backpressure or handshake on the output. Valid words leave stage DEPTH-1 on the next advance whether or not they have been consumed.
- Rising edges of CLKN never change state.
- X/Z on EN or SCLR at an edge:
  - all data and valids go to X;
  - CNT goes to X;
  - this matches the pessimistic X handling of the existing cell library functional models.
- No timing checks (setup/hold/width) in the RTL. They are added by the gate-level wrapper.
- Outputs are glitch-free, driven straight from flops with no combinational path from inputs to outputs.

Test Plan (WIDTH=8, DEPTH=3, RESET_VAL=8'h00 unless stated):
- Reset: pulse R=1 between clock edges with all stages valid → Q=8'h00, QV=0, CNT=0 within the same timestep; the next falling edge after R drops behaves as a normal advance.
- Pipeline fill: EN=1, DV=1, D=8'hA1,8'hB2,8'hC3 on edges 1..3 →
  - CNT = 1, 2, 3 after edges 1, 2, 3;
  - Q=8'hA1 with QV=1 after edge 3;
  - Q=8'hB2 after edge 4.
- Stall: after the fill, hold EN=0 for 5 edges while D toggles → Q=8'hA1, QV=1, CNT=3 unchanged; on resume with DV=0, Q=8'hB2 after the next edge and CNT=2.
- Clear priority: SCLR=1 and EN=1 together, DV=1, D=8'hFF → after the edge QV=0, Q=8'h00, CNT=0, and no 8'hFF appears on Q in the following 3 edges if DV=0.
- GATE_INVALID=1, RESET_VAL=8'h5A: feed D=8'h33 with DV=0 → after 3 edges Q=8'h5A, QV=0. Repeat with GATE_INVALID=0 → Q=8'h33, QV=0.
- Boundary: DEPTH=1 → Q follows D one falling edge later; CNT toggles 0/1 with DV; rising edges cause no change (checked by sampling Q just after each posedge).

Source files
------------

// File: rtl/dffnr_pipe.sv
// Falling-edge delay line with per-stage valid, stall, synchronous clear and occupancy count.
// Drop-in successor to chains of single-bit dffnrnq cells in negative-edge clock domains.
module dffnr_pipe #(
  parameter int              WIDTH        = 8,
  parameter int              DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter bit              GATE_INVALID = 1'b0
) (
  input  logic                       CLKN,
  input  logic                       R,
  input  logic                       EN,
  input  logic                       SCLR,
  input  logic [WIDTH-1:0]           D,
  input  logic                       DV,
  output logic [WIDTH-1:0]           Q,
  output logic                       QV,
  output logic [$clog2(DEPTH+1)-1:0] CNT
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] data_p;
  logic [DEPTH-1:0]            vld_p;
  logic [CW-1:0]               cnt_p;

  logic [DEPTH-1:0][WIDTH-1:0] data_nxt;
  logic [DEPTH-1:0]            vld_nxt;
  logic [CW-1:0]               cnt_nxt;
  logic                        ctl_x;

  function automatic logic [WIDTH-1:0] gate_data(input logic [WIDTH-1:0] d, input logic dv);
    gate_data = (GATE_INVALID && !dv) ? RESET_VAL : d;
  endfunction

  // Modular arithmetic is exact here: the true result always lies in 0..DEPTH.
  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] c, input logic in_v,
                                             input logic out_v);
    cnt_step = c + CW'(in_v) - CW'(out_v);
  endfunction

  // Zero for known controls; X when EN or SCLR is X/Z, poisoning every next-state bit.
  assign ctl_x = (EN ^ EN) | (SCLR ^ SCLR);

  always_comb begin
    data_nxt = data_p;
    vld_nxt  = vld_p;
    cnt_nxt  = cnt_p;
    if (SCLR) begin
      data_nxt = {DEPTH{RESET_VAL}};
      vld_nxt  = '0;
      cnt_nxt  = '0;
    end else if (EN) begin
      data_nxt[0] = gate_data(D, DV);
      vld_nxt[0]  = DV;
      for (int i = 1; i < DEPTH; i++) begin
        data_nxt[i] = data_p[i-1];
        vld_nxt[i]  = vld_p[i-1];
      end
      cnt_nxt = cnt_step(cnt_p, DV, vld_p[DEPTH-1]);
    end
    data_nxt = data_nxt ^ {(DEPTH*WIDTH){ctl_x}};
    vld_nxt  = vld_nxt ^ {DEPTH{ctl_x}};
    cnt_nxt  = cnt_nxt ^ {CW{ctl_x}};
  end

  // Stage registers: falling-edge update, reset takes effect immediately.
  always_ff @(negedge CLKN or posedge R) begin
    if (R) begin
      data_p <= {DEPTH{RESET_VAL}};
      vld_p  <= '0;
      cnt_p  <= '0;
    end else begin
      data_p <= data_nxt;
      vld_p  <= vld_nxt;
      cnt_p  <= cnt_nxt;
    end
  end

  assign Q   = data_p[DEPTH-1];
  assign QV  = vld_p[DEPTH-1];
  assign CNT = cnt_p;

  a_cnt_range : assert property (@(negedge CLKN) disable iff (R) cnt_p <= CW'(DEPTH));
  a_cnt_match : assert property (@(negedge CLKN) disable iff (R) $countones(vld_p) == int'(cnt_p));

endmodule

// File: tb/tb_dffnr_pipe.sv
// Scoreboard bench for dffnr_pipe: four instances (DEPTH=3 plain, DEPTH=3 gated/ungated
// with RESET_VAL=5A, DEPTH=1) driven by directed vectors with hand-computed expectations.
module tb_dffnr_pipe;

  logic CLKN = 1'b1;
  always #5 CLKN = ~CLKN;

  logic       R;
  logic [7:0] d    [3];
  logic       dv   [3];
  logic       en   [3];
  logic       sclr [3];

  logic [7:0] q_o  [4];
  logic       qv_o [4];
  logic [1:0] cnt_a, cnt_b1, cnt_b2;
  logic       cnt_c;

  dffnr_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00), .GATE_INVALID(1'b0)) u0 (
    .CLKN(CLKN), .R(R), .EN(en[0]), .SCLR(sclr[0]), .D(d[0]), .DV(dv[0]),
    .Q(q_o[0]), .QV(qv_o[0]), .CNT(cnt_a));

  dffnr_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A), .GATE_INVALID(1'b1)) u1 (
    .CLKN(CLKN), .R(R), .EN(en[1]), .SCLR(sclr[1]), .D(d[1]), .DV(dv[1]),
    .Q(q_o[1]), .QV(qv_o[1]), .CNT(cnt_b1));

  dffnr_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A), .GATE_INVALID(1'b0)) u2 (
    .CLKN(CLKN), .R(R), .EN(en[1]), .SCLR(sclr[1]), .D(d[1]), .DV(dv[1]),
    .Q(q_o[2]), .QV(qv_o[2]), .CNT(cnt_b2));

  dffnr_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00), .GATE_INVALID(1'b0)) u3 (
    .CLKN(CLKN), .R(R), .EN(en[2]), .SCLR(sclr[2]), .D(d[2]), .DV(dv[2]),
    .Q(q_o[3]), .QV(qv_o[3]), .CNT(cnt_c));

  typedef struct {
    int         id;
    logic [7:0] q;
    logic       qv;
    logic [1:0] cnt;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  event chk_ev;

  exp_t       mon_e;
  logic [7:0] act_q;
  logic       act_qv;
  logic [1:0] act_cnt;

  task automatic exp_push(input int id, input logic [7:0] q, input logic qv,
                          input logic [1:0] cnt, input string tag);
    exp_t e;
    e.id = id; e.q = q; e.qv = qv; e.cnt = cnt; e.tag = tag;
    sb.push_back(e);
  endtask

  // Monitor: outputs settle 1 time unit after each falling edge or an explicit check request.
  initial begin
    forever begin
      @(negedge CLKN or chk_ev);
      #1;
      while (sb.size() > 0) begin
        mon_e = sb.pop_front();
        case (mon_e.id)
          0:       begin act_q = q_o[0]; act_qv = qv_o[0]; act_cnt = cnt_a;          end
          1:       begin act_q = q_o[1]; act_qv = qv_o[1]; act_cnt = cnt_b1;         end
          2:       begin act_q = q_o[2]; act_qv = qv_o[2]; act_cnt = cnt_b2;         end
          default: begin act_q = q_o[3]; act_qv = qv_o[3]; act_cnt = {1'b0, cnt_c}; end
        endcase
        n_chk++;
        if (act_q !== mon_e.q || act_qv !== mon_e.qv || act_cnt !== mon_e.cnt) begin
          n_fail++;
          $display("FAIL %s (u%0d): got Q=%h QV=%b CNT=%0d, expected Q=%h QV=%b CNT=%0d",
                   mon_e.tag, mon_e.id, act_q, act_qv, act_cnt, mon_e.q, mon_e.qv, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge CLKN);
    #2;
  endtask

  task automatic drive(input int g, input logic [7:0] dd, input logic v, input logic e,
                       input logic s);
    d[g] = dd; dv[g] = v; en[g] = e; sclr[g] = s;
  endtask

  task automatic a_step(input logic [7:0] dd, input logic v, input logic e, input logic s,
                        input logic [7:0] q, input logic qv, input logic [1:0] cnt,
                        input string tag);
    drive(0, dd, v, e, s);
    exp_push(0, q, qv, cnt, tag);
    tick();
  endtask

  task automatic b_step(input logic [7:0] dd, input logic v, input logic s,
                        input logic [7:0] q1, input logic [7:0] q2, input logic qv,
                        input logic [1:0] cnt, input string tag);
    drive(1, dd, v, 1'b1, s);
    exp_push(1, q1, qv, cnt, {tag, "_gated"});
    exp_push(2, q2, qv, cnt, {tag, "_ungated"});
    tick();
  endtask

  // After the falling edge the inputs are scrambled, then state is re-checked past the rising edge.
  task automatic c_step(input logic [7:0] dd, input logic v, input logic e,
                        input logic [7:0] q, input logic qv, input logic cnt, input string tag);
    drive(2, dd, v, e, 1'b0);
    exp_push(3, q, qv, {1'b0, cnt}, tag);
    tick();
    d[2]  = ~dd;
    dv[2] = ~v;
    @(posedge CLKN);
    #1;
    exp_push(3, q, qv, {1'b0, cnt}, {tag, "_posedge"});
    -> chk_ev;
    #3;
  endtask

  initial begin
    R = 1'b1;
    for (int g = 0; g < 3; g++) begin
      d[g] = 8'h00; dv[g] = 1'b0; en[g] = 1'b0; sclr[g] = 1'b0;
    end
    #2;
    exp_push(0, 8'h00, 1'b0, 2'd0, "reset_u0");
    exp_push(1, 8'h5A, 1'b0, 2'd0, "reset_u1");
    exp_push(2, 8'h5A, 1'b0, 2'd0, "reset_u2");
    exp_push(3, 8'h00, 1'b0, 2'd0, "reset_u3");
    -> chk_ev;
    #2;
    R = 1'b0;
    tick();

    // DEPTH=1: one-edge latency, CNT follows DV, stall holds
    c_step(8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, "d1_e1");
    c_step(8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, "d1_e2");
    c_step(8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, "d1_e3");
    c_step(8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, "d1_e4");
    c_step(8'hFF, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, "d1_stall");
    c_step(8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "d1_e6");
    drive(2, 8'h00, 1'b0, 1'b0, 1'b0);

    // GATE_INVALID: invalid words become 5A only in the gated instance
    b_step(8'h33, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0, 2'd0, "gate_e1");
    b_step(8'h33, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0, 2'd0, "gate_e2");
    b_step(8'h33, 1'b0, 1'b0, 8'h5A, 8'h33, 1'b0, 2'd0, "gate_e3");
    b_step(8'h44, 1'b1, 1'b0, 8'h5A, 8'h33, 1'b0, 2'd1, "gate_e4");
    b_step(8'h33, 1'b0, 1'b0, 8'h5A, 8'h33, 1'b0, 2'd1, "gate_e5");
    b_step(8'h33, 1'b0, 1'b0, 8'h44, 8'h44, 1'b1, 2'd1, "gate_e6");
    b_step(8'h33, 1'b0, 1'b0, 8'h5A, 8'h33, 1'b0, 2'd0, "gate_e7");
    b_step(8'h77, 1'b1, 1'b1, 8'h5A, 8'h5A, 1'b0, 2'd0, "gate_sclr");
    drive(1, 8'h00, 1'b0, 1'b0, 1'b0);

    // DEPTH=3: fill, stall, drain with DV=0, refill
    a_step(8'hA1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, "fill_e1");
    a_step(8'hB2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd2, "fill_e2");
    a_step(8'hC3, 1'b1, 1'b1, 1'b0, 8'hA1, 1'b1, 2'd3, "fill_e3");
    a_step(8'h5A, 1'b1, 1'b0, 1'b0, 8'hA1, 1'b1, 2'd3, "stall_1");
    a_step(8'hA5, 1'b0, 1'b0, 1'b0, 8'hA1, 1'b1, 2'd3, "stall_2");
    a_step(8'hFF, 1'b1, 1'b0, 1'b0, 8'hA1, 1'b1, 2'd3, "stall_3");
    a_step(8'h00, 1'b0, 1'b0, 1'b0, 8'hA1, 1'b1, 2'd3, "stall_4");
    a_step(8'h3C, 1'b1, 1'b0, 1'b0, 8'hA1, 1'b1, 2'd3, "stall_5");
    a_step(8'h00, 1'b0, 1'b1, 1'b0, 8'hB2, 1'b1, 2'd2, "resume");
    a_step(8'hD4, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 2'd2, "in_out");
    a_step(8'hE5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd2, "bubble_out");
    a_step(8'hF6, 1'b1, 1'b1, 1'b0, 8'hD4, 1'b1, 2'd3, "refill");

    // Asynchronous reset pulse between edges with every stage valid
    R = 1'b1;
    exp_push(0, 8'h00, 1'b0, 2'd0, "async_reset");
    -> chk_ev;
    #2;
    R = 1'b0;

    a_step(8'h17, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, "post_reset");
    a_step(8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 2'd0, "sclr_prio");
    a_step(8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, "after_sclr1");
    a_step(8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, "after_sclr2");
    a_step(8'h33, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 2'd0, "after_sclr3");
    drive(0, 8'h00, 1'b0, 1'b0, 1'b0);

    tick();
    tick();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
